csr_file: RTL and testbench

- Architectural CSR storage that is the destination of the execute-stage CSR write port (`csrWrEn`/`csrWrAddr`/`csrWrData`) and the source of the CSR read value returned as the ALU's second operand.
- Execute-stage writes are speculative. They are held in an in-order pending-write buffer, applied to architectural state only on retire, and discarded on flush.
- Also owns the cycle and instret counters and FP exception-flag accrual.

---
 rtl/csr_file_pkg.sv | 52 +++++
 rtl/csr_file_pend_fifo.sv | 78 +++++++
 rtl/csr_file.sv | 109 ++++++++++
 tb/tb_csr_file.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - CSR address map, pending-write packet and address helpers
package csr_file_pkg;

  localparam int CSR_DATA_W       = 64;
  localparam int CSR_ADDR_W       = 12;
  localparam int PEND_DEPTH_DEF   = 4;
  localparam int COMMIT_WIDTH_DEF = 4;
  localparam int NUM_SCRATCH      = 4;

  localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS   = 12'h001;
  localparam logic [CSR_ADDR_W-1:0] CSR_FRM      = 12'h002;
  localparam logic [CSR_ADDR_W-1:0] CSR_FCSR     = 12'h003;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIME     = 12'hC01;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIMEH    = 12'hC81;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH = 12'hC82;
  localparam logic [CSR_ADDR_W-1:0] CSR_SCRATCH  = 12'h340;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] data;
  } csrPendPkt;

  function automatic logic is_fp_addr(input logic [CSR_ADDR_W-1:0] a);
    return (a == CSR_FFLAGS) || (a == CSR_FRM) || (a == CSR_FCSR);
  endfunction

  function automatic logic is_scratch(input logic [CSR_ADDR_W-1:0] a);
    logic [CSR_ADDR_W-1:0] off;
    off = a - CSR_SCRATCH;
    return off < CSR_ADDR_W'(NUM_SCRATCH);
  endfunction

  function automatic logic is_counter(input logic [CSR_ADDR_W-1:0] a);
    return (a == CSR_CYCLE) || (a == CSR_TIME) || (a == CSR_INSTRET) ||
           (a == CSR_CYCLEH) || (a == CSR_TIMEH) || (a == CSR_INSTRETH);
  endfunction

  // Bits of a write that survive into architectural state at this address.
  function automatic logic [CSR_DATA_W-1:0] wr_mask(input logic [CSR_ADDR_W-1:0] a);
    logic [CSR_DATA_W-1:0] m;
    m = '0;
    if (a == CSR_FFLAGS)    m = CSR_DATA_W'(8'h1F);
    else if (a == CSR_FRM)  m = CSR_DATA_W'(8'h07);
    else if (a == CSR_FCSR) m = CSR_DATA_W'(8'hFF);
    else if (is_scratch(a)) m = '1;
    return m;
  endfunction

endpackage

// File: rtl/csr_file_pend_fifo.sv
// rtl/csr_file_pend_fifo.sv - in-order speculative CSR write buffer with youngest-match lookup
module csr_pend_fifo
  import csr_file_pkg::*;
#(
  parameter int DEPTH = PEND_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  csrPendPkt             push_pkt_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic                  full_o,
  output logic                  empty_o,
  output csrPendPkt             head_pkt_o,
  input  logic [CSR_ADDR_W-1:0] lookup_addr_i,
  output logic                  hit_o,
  output logic [CSR_DATA_W-1:0] hit_data_o,
  output logic                  fp_conflict_o
);

  localparam int IDX_W = $clog2(DEPTH);

  csrPendPkt        mem_q [DEPTH];
  logic [IDX_W:0]   head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count;
  logic             do_push;
  csrPendPkt        slot;

  assign count      = tail_q - head_q;
  assign empty_o    = (head_q == tail_q);
  assign full_o     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign head_pkt_o = mem_q[head_q[IDX_W-1:0]];
  assign do_push    = push_i && !full_o && !clear_i;

  // A clear lands after any same-cycle pop, so the head still retires first.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_i && !empty_o) head_d = head_q + 1'b1;
    if (clear_i)           head_d = tail_q;
    else if (do_push)      tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q[IDX_W-1:0]] <= push_pkt_i;
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o         = 1'b0;
    hit_data_o    = '0;
    fp_conflict_o = 1'b0;
    slot          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((IDX_W+1)'(i) < count) begin
        slot = mem_q[head_q[IDX_W-1:0] + IDX_W'(i)];
        if (slot.addr == lookup_addr_i) begin
          hit_o      = 1'b1;
          hit_data_o = slot.data;
        end
        if (is_fp_addr(lookup_addr_i) && is_fp_addr(slot.addr) && (slot.addr != lookup_addr_i))
          fp_conflict_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - architectural CSRs with speculative write buffer, counters and FP flag accrual
module csr_file
  import csr_file_pkg::*;
#(
  parameter int CSR_WIDTH     = CSR_DATA_W,
  parameter int CSR_WIDTH_LOG = CSR_ADDR_W,
  parameter int PEND_DEPTH    = PEND_DEPTH_DEF,
  parameter int COMMIT_WIDTH  = COMMIT_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [CSR_WIDTH_LOG-1:0]           csrRdAddr_i,
  output logic [CSR_WIDTH-1:0]               csrRdData_o,
  output logic                               csrRdStall_o,
  input  logic                               csrWrEn_i,
  input  logic [CSR_WIDTH_LOG-1:0]           csrWrAddr_i,
  input  logic [CSR_WIDTH-1:0]               csrWrData_i,
  output logic                               csrWrReady_o,
  input  logic                               csrCommit_i,
  input  logic                               flush_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]  commitCnt_i,
  input  logic                               fpFlagsValid_i,
  input  logic [4:0]                         fpFlags_i,
  output logic [2:0]                         frm_o,
  output logic                               commitErr_o
);

  logic [4:0]           fflags_q, fflags_d;
  logic [2:0]           frm_q, frm_d;
  logic [CSR_WIDTH-1:0] cycle_q, instret_q;
  logic [CSR_WIDTH-1:0] scratch_q [NUM_SCRATCH];
  logic [CSR_WIDTH-1:0] scratch_d [NUM_SCRATCH];
  logic                 err_q;

  logic                 fifo_full, fifo_empty, hit, fp_conflict, do_commit;
  logic [CSR_WIDTH-1:0] hit_data, arch_rd;
  csrPendPkt            head_pkt, push_pkt;

  assign push_pkt     = '{addr: csrWrAddr_i, data: csrWrData_i};
  assign csrWrReady_o = !fifo_full;
  assign do_commit    = csrCommit_i && !fifo_empty;
  assign frm_o        = frm_q;
  assign commitErr_o  = err_q;

  csr_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_i        (csrWrEn_i),
    .push_pkt_i    (push_pkt),
    .pop_i         (csrCommit_i),
    .clear_i       (flush_i),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_pkt_o    (head_pkt),
    .lookup_addr_i (csrRdAddr_i),
    .hit_o         (hit),
    .hit_data_o    (hit_data),
    .fp_conflict_o (fp_conflict)
  );

  // Retiring write lands first; freshly raised FP flags are ORed on top.
  always_comb begin
    fflags_d  = fflags_q;
    frm_d     = frm_q;
    scratch_d = scratch_q;
    if (do_commit) begin
      if (head_pkt.addr == CSR_FFLAGS || head_pkt.addr == CSR_FCSR) fflags_d = head_pkt.data[4:0];
      if (head_pkt.addr == CSR_FRM)  frm_d = head_pkt.data[2:0];
      if (head_pkt.addr == CSR_FCSR) frm_d = head_pkt.data[7:5];
      if (is_scratch(head_pkt.addr)) scratch_d[head_pkt.addr[1:0]] = head_pkt.data;
    end
    if (fpFlagsValid_i) fflags_d = fflags_d | fpFlags_i;
  end

  always_comb begin
    arch_rd = '0;
    case (csrRdAddr_i)
      CSR_FFLAGS:                                 arch_rd = CSR_WIDTH'(fflags_q);
      CSR_FRM:                                    arch_rd = CSR_WIDTH'(frm_q);
      CSR_FCSR:                                   arch_rd = CSR_WIDTH'({frm_q, fflags_q});
      CSR_CYCLE, CSR_TIME, CSR_CYCLEH, CSR_TIMEH: arch_rd = cycle_q;
      CSR_INSTRET, CSR_INSTRETH:                  arch_rd = instret_q;
      default: if (is_scratch(csrRdAddr_i))       arch_rd = scratch_q[csrRdAddr_i[1:0]];
    endcase
  end

  // Bypassed data is masked so it matches what the write will leave behind once it retires.
  assign csrRdData_o  = (hit && !is_counter(csrRdAddr_i)) ? (hit_data & wr_mask(csrRdAddr_i)) : arch_rd;
  assign csrRdStall_o = fp_conflict;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fflags_q  <= '0;
      frm_q     <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      scratch_q <= '{default: '0};
      err_q     <= 1'b0;
    end else begin
      fflags_q  <= fflags_d;
      frm_q     <= frm_d;
      scratch_q <= scratch_d;
      cycle_q   <= cycle_q + 1'b1;
      instret_q <= instret_q + CSR_WIDTH'(commitCnt_i);
      if (csrCommit_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed vector table plus randomized run against a queue-based CSR model
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] csrRdAddr_i;
  logic [63:0] csrRdData_o;
  logic        csrRdStall_o;
  logic        csrWrEn_i;
  logic [11:0] csrWrAddr_i;
  logic [63:0] csrWrData_i;
  logic        csrWrReady_o;
  logic        csrCommit_i;
  logic        flush_i;
  logic [2:0]  commitCnt_i;
  logic        fpFlagsValid_i;
  logic [4:0]  fpFlags_i;
  logic [2:0]  frm_o;
  logic        commitErr_o;

  always #5 clk = ~clk;

  csr_file dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csrRdAddr_i    (csrRdAddr_i),
    .csrRdData_o    (csrRdData_o),
    .csrRdStall_o   (csrRdStall_o),
    .csrWrEn_i      (csrWrEn_i),
    .csrWrAddr_i    (csrWrAddr_i),
    .csrWrData_i    (csrWrData_i),
    .csrWrReady_o   (csrWrReady_o),
    .csrCommit_i    (csrCommit_i),
    .flush_i        (flush_i),
    .commitCnt_i    (commitCnt_i),
    .fpFlagsValid_i (fpFlagsValid_i),
    .fpFlags_i      (fpFlags_i),
    .frm_o          (frm_o),
    .commitErr_o    (commitErr_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending writes as a queue, architectural state as plain variables.
  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         m_pend[$];
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic [63:0] m_scratch[4];
  logic [63:0] m_cycle, m_instret;
  logic        m_err;

  function automatic bit m_is_fp(input logic [11:0] a);
    return a == 12'h001 || a == 12'h002 || a == 12'h003;
  endfunction

  function automatic logic [63:0] m_visible(input logic [11:0] a, input logic [63:0] d);
    if (a == 12'h001) return {59'd0, d[4:0]};
    if (a == 12'h002) return {61'd0, d[2:0]};
    if (a == 12'h003) return {56'd0, d[7:0]};
    if (a >= 12'h340 && a <= 12'h343) return d;
    return 64'd0;
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    if (a == 12'hC00 || a == 12'hC01 || a == 12'hC80 || a == 12'hC81) return m_cycle;
    if (a == 12'hC02 || a == 12'hC82) return m_instret;
    for (int i = m_pend.size() - 1; i >= 0; i--)
      if (m_pend[i].addr == a) return m_visible(a, m_pend[i].data);
    if (a == 12'h001) return {59'd0, m_fflags};
    if (a == 12'h002) return {61'd0, m_frm};
    if (a == 12'h003) return {56'd0, m_frm, m_fflags};
    if (a >= 12'h340 && a <= 12'h343) return m_scratch[int'(a - 12'h340)];
    return 64'd0;
  endfunction

  function automatic bit model_stall(input logic [11:0] a);
    if (!m_is_fp(a)) return 1'b0;
    foreach (m_pend[i])
      if (m_is_fp(m_pend[i].addr) && m_pend[i].addr != a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step();
    logic [4:0] nf;
    bit         was_ready;
    wr_t        w;
    if (!reset_n) begin
      m_pend.delete();
      m_fflags  = '0;
      m_frm     = '0;
      m_scratch = '{default: '0};
      m_cycle   = '0;
      m_instret = '0;
      m_err     = 1'b0;
      return;
    end
    was_ready = m_pend.size() < 4;
    m_cycle   = m_cycle + 64'd1;
    m_instret = m_instret + 64'(commitCnt_i);
    nf = m_fflags;
    if (csrCommit_i) begin
      if (m_pend.size() == 0) m_err = 1'b1;
      else begin
        w = m_pend.pop_front();
        if (w.addr == 12'h001) nf = w.data[4:0];
        else if (w.addr == 12'h002) m_frm = w.data[2:0];
        else if (w.addr == 12'h003) begin
          nf    = w.data[4:0];
          m_frm = w.data[7:5];
        end else if (w.addr >= 12'h340 && w.addr <= 12'h343)
          m_scratch[int'(w.addr - 12'h340)] = w.data;
      end
    end
    if (fpFlagsValid_i) nf = nf | fpFlags_i;
    m_fflags = nf;
    if (flush_i) m_pend.delete();
    else if (csrWrEn_i && was_ready) m_pend.push_back('{csrWrAddr_i, csrWrData_i});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csrWrEn_i = 0; csrWrAddr_i = 0; csrWrData_i = 0; csrCommit_i = 0; flush_i = 0;
    commitCnt_i = 0; fpFlagsValid_i = 0; fpFlags_i = 0; csrRdAddr_i = 0;
  endtask

  typedef struct {
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        cmt, fl;
    logic [2:0]  cnt;
    logic        fpv;
    logic [4:0]  fpf;
    logic [11:0] raddr;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic        exp_stall, exp_ready;
    logic [2:0]  exp_frm;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rd(input logic [11:0] ra, input logic [63:0] er);
    vec_t t;
    t = '{wen: 0, waddr: 0, wdata: 0, cmt: 0, fl: 0, cnt: 0, fpv: 0, fpf: 0,
          raddr: ra, chk_rd: 1, exp_rd: er, exp_stall: 0, exp_ready: 1, exp_frm: 0, exp_err: 0};
    return t;
  endfunction

  function automatic vec_t wr(input vec_t b, input logic [11:0] wa, input logic [63:0] wd);
    vec_t t;
    t = b; t.wen = 1; t.waddr = wa; t.wdata = wd;
    return t;
  endfunction

  logic [11:0] addr_pool[10] = '{12'h001, 12'h002, 12'h003, 12'h340, 12'h341,
                                 12'h343, 12'hC00, 12'hC02, 12'hC82, 12'h123};

  initial begin
    vec_t t;
    reset_n = 0;
    idle_inputs();

    // Counters and basic reads.
    vecs.push_back(rd(12'h002, 64'd0));
    for (int k = 1; k <= 10; k++) begin
      t = rd(12'hC00, 64'(k));
      if (k == 10) t.cnt = 3;
      vecs.push_back(t);
    end
    t = rd(12'hC02, 64'd3); t.cnt = 3; vecs.push_back(t);
    vecs.push_back(rd(12'hC02, 64'd6));
    vecs.push_back(rd(12'hC82, 64'd6));
    // Bypass then architectural read of scratch.
    vecs.push_back(wr(rd(12'h340, 64'd0), 12'h340, 64'hDEAD));
    t = rd(12'h340, 64'hDEAD); t.cmt = 1; vecs.push_back(t);
    vecs.push_back(rd(12'h340, 64'hDEAD));
    // Fill the buffer; 5th push collides with a commit and must be dropped.
    for (int j = 0; j < 4; j++) vecs.push_back(wr(rd(12'h342, 64'(8'h11 * j)), 12'h342, 64'(8'h11 * (j + 1))));
    t = wr(rd(12'h342, 64'h44), 12'h342, 64'h55); t.cmt = 1; t.exp_ready = 0; vecs.push_back(t);
    for (int j = 0; j < 3; j++) begin t = rd(12'h342, 64'h44); t.cmt = 1; vecs.push_back(t); end
    vecs.push_back(rd(12'h342, 64'h44));
    // Flush with same-cycle commit keeps only the head write.
    vecs.push_back(wr(rd(12'h341, 64'd0), 12'h341, 64'd1));
    vecs.push_back(wr(rd(12'h341, 64'd1), 12'h341, 64'd2));
    t = rd(12'h341, 64'd2); t.cmt = 1; t.fl = 1; vecs.push_back(t);
    vecs.push_back(rd(12'h341, 64'd1));
    // fcsr pending against an fflags read, then commit with accrued flags.
    vecs.push_back(wr(rd(12'h001, 64'd0), 12'h003, 64'hE5));
    t = rd(12'h001, 64'd0); t.chk_rd = 0; t.exp_stall = 1; vecs.push_back(t);
    t = rd(12'h003, 64'hE5); t.cmt = 1; t.fpv = 1; t.fpf = 5'h02; vecs.push_back(t);
    t = rd(12'h001, 64'h07); t.exp_frm = 7; vecs.push_back(t);
    t = rd(12'h003, 64'hE7); t.exp_frm = 7; vecs.push_back(t);
    // Commit with an empty buffer raises the sticky error.
    t = rd(12'h002, 64'd7); t.exp_frm = 7; t.cmt = 1; vecs.push_back(t);
    t = rd(12'h002, 64'd7); t.exp_frm = 7; t.exp_err = 1; vecs.push_back(t);
    vecs.push_back(t);

    tick();
    tick();
    reset_n = 1;

    foreach (vecs[i]) begin
      csrWrEn_i = vecs[i].wen; csrWrAddr_i = vecs[i].waddr; csrWrData_i = vecs[i].wdata;
      csrCommit_i = vecs[i].cmt; flush_i = vecs[i].fl; commitCnt_i = vecs[i].cnt;
      fpFlagsValid_i = vecs[i].fpv; fpFlags_i = vecs[i].fpf; csrRdAddr_i = vecs[i].raddr;
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), csrRdData_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_stall", i), 64'(csrRdStall_o), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d_ready", i), 64'(csrWrReady_o), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_frm", i), 64'(frm_o), 64'(vecs[i].exp_frm));
      check($sformatf("vec%0d_err", i), 64'(commitErr_o), 64'(vecs[i].exp_err));
      tick();
    end

    // Sticky error survives idle cycles and only a reset edge clears it.
    idle_inputs();
    csrRdAddr_i = 12'hC00;
    #1;
    check("err_sticky", 64'(commitErr_o), 64'd1);
    reset_n = 0;
    #1;
    check("err_before_reset_edge", 64'(commitErr_o), 64'd1);
    tick();
    reset_n = 1;
    #1;
    check("rst_err", 64'(commitErr_o), 64'd0);
    check("rst_frm", 64'(frm_o), 64'd0);
    check("rst_cycle", csrRdData_o, 64'd0);
    check("rst_ready", 64'(csrWrReady_o), 64'd1);
    check("rst_stall", 64'(csrRdStall_o), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      reset_n        = ($urandom_range(0, 99) != 0);
      csrWrEn_i      = ($urandom_range(0, 2) != 0);
      csrWrAddr_i    = addr_pool[$urandom_range(0, 9)];
      csrWrData_i    = {$urandom(), $urandom()};
      csrCommit_i    = ($urandom_range(0, 2) == 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      commitCnt_i    = 3'($urandom_range(0, 4));
      fpFlagsValid_i = ($urandom_range(0, 3) == 0);
      fpFlags_i      = 5'($urandom());
      csrRdAddr_i    = addr_pool[$urandom_range(0, 9)];
      #1;
      if (!model_stall(csrRdAddr_i))
        check($sformatf("rnd%0d_rd_%0h", c, csrRdAddr_i), csrRdData_o, model_read(csrRdAddr_i));
      check($sformatf("rnd%0d_stall", c), 64'(csrRdStall_o), 64'(model_stall(csrRdAddr_i)));
      check($sformatf("rnd%0d_ready", c), 64'(csrWrReady_o), 64'(m_pend.size() < 4));
      check($sformatf("rnd%0d_frm", c), 64'(frm_o), 64'(m_frm));
      check($sformatf("rnd%0d_err", c), 64'(commitErr_o), 64'(m_err));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
